// File: rtl/ext_bus_bridge.sv
// DM-stage bus bridge: decodes accesses to internal DM, NCH external channels or unmapped space.
// Latency: internal/unmapped combinational; external min 2 stall cycles, data returned in DONE.
// Backpressure: cpu_stall holds the pipeline until the selected channel acks or the timeout expires.
module ext_bus_bridge #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int RB      = 3,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic              cpu_re,
  input  logic              cpu_we,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_stall,
  output logic              dm_re,
  output logic              dm_we,
  input  logic [DW-1:0]     dm_rdata,
  output logic [NCH-1:0]    ext_sel,
  output logic [AW-1:0]     ext_addr,
  output logic [DW-1:0]     ext_wdata,
  output logic              ext_re,
  output logic              ext_we,
  input  logic [NCH*DW-1:0] ext_rdata,
  input  logic [NCH-1:0]    ext_ack,
  output logic              err,
  output logic [AW-1:0]     err_addr,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [RB-1:0]   NCH_R   = RB'(NCH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  logic [NCH-1:0]  ext_sel_q;
  logic [AW-1:0]   ext_addr_q;
  logic [DW-1:0]   ext_wdata_q;
  logic            ext_re_q;
  logic            ext_we_q;
  logic            dir_rd_q;
  logic [TO_W-1:0] cnt_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [AW-1:0]   err_addr_q;

  logic [RB-1:0]   region;
  logic            acc;
  logic            is_int;
  logic            is_ext;
  logic            is_unm;
  logic [NCH-1:0]  sel_d;
  logic            ack_hit;
  logic [DW-1:0]   ack_data;
  logic            timeout;
  logic            set_err;
  logic [AW-1:0]   err_src;

  // Region decode of the DM-stage address and one-hot channel select
  always_comb begin
    region = cpu_addr[AW-1 -: RB];
    acc    = cpu_re | cpu_we;
    is_int = (region == '0);
    is_ext = !is_int && (region <= NCH_R);
    is_unm = !is_int && !is_ext;
    sel_d  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (region == RB'(k + 1)) sel_d[k] = 1'b1;
    end
  end

  // Ack detection on the latched channel only; other channels' acks are ignored
  always_comb begin
    ack_hit  = |(ext_ack & ext_sel_q);
    ack_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ext_sel_q[k]) ack_data = ack_data | ext_rdata[k*DW +: DW];
    end
    timeout = (cnt_q == TO_LAST);
  end

  // External access FSM: latch request in IDLE, hold strobes through REQ, return data in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ext_sel_q   <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_re_q    <= 1'b0;
      ext_we_q    <= 1'b0;
      dir_rd_q    <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc && is_ext) begin
            ext_sel_q   <= sel_d;
            ext_addr_q  <= cpu_addr;
            ext_wdata_q <= cpu_wdata;
            // a simultaneous load+store is handled as a store
            ext_we_q    <= cpu_we;
            ext_re_q    <= cpu_re & ~cpu_we;
            dir_rd_q    <= ~cpu_we;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + TO_W'(1);
          if (ack_hit || timeout) begin
            // an ack in the timeout cycle still delivers real data
            rdata_q   <= ack_hit ? ack_data : '1;
            ext_sel_q <= '0;
            ext_re_q  <= 1'b0;
            ext_we_q  <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // the pipeline advances on this edge, so the request is not re-issued
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Error sources: unmapped access seen in IDLE, or timeout without ack in REQ
  always_comb begin
    set_err = (state_q == IDLE && acc && is_unm) ||
              (state_q == REQ && !ack_hit && timeout);
    err_src = (state_q == REQ) ? ext_addr_q : cpu_addr;
  end

  // Sticky error flag; only the first faulting address since clear is kept, set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (set_err) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= err_src;
    end else if (err_clr) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end
  end

  // CPU-side outputs: internal pass-through, stall while an external access is outstanding
  always_comb begin
    cpu_stall = rst_n && ((state_q == IDLE && acc && is_ext) || state_q == REQ);
    dm_re     = (state_q == IDLE) && is_int && cpu_re && !cpu_we;
    dm_we     = (state_q == IDLE) && is_int && cpu_we;
    if (state_q == DONE && dir_rd_q) begin
      cpu_rdata = rdata_q;
    end else if (state_q == IDLE && is_int && cpu_re && !cpu_we) begin
      cpu_rdata = dm_rdata;
    end else begin
      cpu_rdata = '0;
    end
  end

  assign ext_sel   = ext_sel_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_re    = ext_re_q;
  assign ext_we    = ext_we_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
